// File: rtl/pipelined_adder_tree.sv
// Fully pipelined binary adder tree over 2**N_STAGE unsigned lanes, followed by an
// output stage that either passes each beat sum through or builds a saturating frame total.
module pipelined_adder_tree #(
   parameter int N_STAGE = 4,
   parameter int IN_W    = 2,
   parameter int ACC_W   = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic [(2**N_STAGE)*IN_W-1:0]   in_data,
   input  logic                           in_last,
   input  logic                           acc_mode,
   output logic                           out_valid,
   output logic [ACC_W-1:0]               sum_out,
   output logic                           sat_out
);

   localparam int N_IN  = 2**N_STAGE;
   localparam int SUM_W = IN_W + N_STAGE;

   // Bit offset of tree level k inside the flattened w_tree vector.
   function automatic int lvl_off(input int k);
      int o;
      o = 0;
      for (int j = 0; j < k; j++) o += (N_IN >> j) * (IN_W + j);
      return o;
   endfunction

   localparam int TREE_W   = lvl_off(N_STAGE + 1);
   localparam int ROOT_OFF = lvl_off(N_STAGE);

   function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                              input logic [SUM_W-1:0] s);
      return {1'b0, acc} + (ACC_W+1)'(s);
   endfunction

   function automatic logic [ACC_W-1:0] sat_clip(input logic [ACC_W:0] t);
      return t[ACC_W] ? {ACC_W{1'b1}} : t[ACC_W-1:0];
   endfunction

   if (ACC_W < IN_W + N_STAGE || N_STAGE < 1) begin : g_bad_cfg
      $fatal(1, "pipelined_adder_tree: ACC_W must be >= IN_W+N_STAGE and N_STAGE >= 1");
   end

   logic [TREE_W-1:0]       w_tree;
   logic [N_IN*IN_W-1:0]    r_lane;
   logic [N_STAGE:0]        r_vld_pipe;
   logic [N_STAGE:0]        r_last_pipe;
   logic [N_STAGE:0]        r_mode_pipe;
   logic [ACC_W-1:0]        r_acc;
   logic                    r_satf;
   logic [SUM_W-1:0]        w_root;
   logic [ACC_W:0]          w_total;
   logic [ACC_W-1:0]        w_clip;
   logic                    w_ovf;

   // Stage 0: registered lanes
   always_ff @(posedge clk) begin
      r_lane <= in_data;
   end
   assign w_tree[0 +: N_IN*IN_W] = r_lane;

   // Stages 1..N_STAGE: each node grows by one bit so it can never overflow
   for (genvar k = 1; k <= N_STAGE; k++) begin : g_lvl
      localparam int NN = N_IN >> k;
      localparam int NW = IN_W + k;
      localparam int PW = NW - 1;
      localparam int PO = lvl_off(k - 1);
      localparam int OO = lvl_off(k);

      logic [NN*NW-1:0] r_lvl;

      always_ff @(posedge clk) begin
         for (int i = 0; i < NN; i++) begin
            r_lvl[i*NW +: NW] <= {1'b0, w_tree[PO + (2*i)*PW +: PW]}
                               + {1'b0, w_tree[PO + (2*i+1)*PW +: PW]};
         end
      end
      assign w_tree[OO +: NN*NW] = r_lvl;
   end

   // Tags ride alongside the data so a mode change only affects its own beat
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
         r_mode_pipe <= '0;
      end else begin
         r_vld_pipe  <= {r_vld_pipe[N_STAGE-1:0],  in_valid};
         r_last_pipe <= {r_last_pipe[N_STAGE-1:0], in_last};
         r_mode_pipe <= {r_mode_pipe[N_STAGE-1:0], acc_mode};
      end
   end

   assign w_root  = w_tree[ROOT_OFF +: SUM_W];
   assign w_total = acc_add(r_acc, w_root);
   assign w_ovf   = w_total[ACC_W];
   assign w_clip  = sat_clip(w_total);

   // Output / accumulator stage
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         sum_out   <= '0;
         sat_out   <= 1'b0;
         r_acc     <= '0;
         r_satf    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (r_vld_pipe[N_STAGE]) begin
            if (!r_mode_pipe[N_STAGE]) begin
               // Pass-through also abandons any partial frame
               sum_out   <= ACC_W'(w_root);
               sat_out   <= 1'b0;
               out_valid <= 1'b1;
               r_acc     <= '0;
               r_satf    <= 1'b0;
            end else if (!r_last_pipe[N_STAGE]) begin
               r_acc     <= w_clip;
               r_satf    <= r_satf | w_ovf;
            end else begin
               sum_out   <= w_clip;
               sat_out   <= r_satf | w_ovf;
               out_valid <= 1'b1;
               r_acc     <= '0;
               r_satf    <= 1'b0;
            end
         end
      end
   end

endmodule
